// File: rtl/core_pkg.sv
// core_pkg: shared widths, ALU control codes, alu_op encodings and ALU-control decode
package core_pkg;
    localparam int XLEN = 64;
    localparam int RA_W = 5;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [1:0] AOP_ADD   = 2'b00;
    localparam logic [1:0] AOP_SUB   = 2'b01;
    localparam logic [1:0] AOP_FUNCT = 2'b10;

    // Immediate forms never subtract: bit 30 is part of the immediate there.
    function automatic logic [3:0] alu_decode(input logic [1:0] op, input logic [2:0] f3,
                                              input logic f7b5, input logic alu_src);
        return op == AOP_SUB   ? ALU_SUB :
               op != AOP_FUNCT ? ALU_ADD :
               f3 == 3'b111    ? ALU_AND :
               f3 == 3'b110    ? ALU_OR  :
               (f3 == 3'b000 && f7b5 && !alu_src) ? ALU_SUB : ALU_ADD;
    endfunction
endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// fwd_mux: picks EX/MEM, then MEM/WB, then register-file data for one source; x0 never forwarded
module fwd_mux
    import core_pkg::*;
(
    input  logic [RA_W-1:0] src,
    input  logic [XLEN-1:0] reg_data,
    input  logic            exm_reg_write,
    input  logic [RA_W-1:0] exm_rd,
    input  logic [XLEN-1:0] exm_result,
    input  logic            mwb_reg_write,
    input  logic [RA_W-1:0] mwb_rd,
    input  logic [XLEN-1:0] mwb_result,
    output logic [XLEN-1:0] data
);
    assign data = (exm_reg_write && exm_rd != '0 && exm_rd == src) ? exm_result :
                  (mwb_reg_write && mwb_rd != '0 && mwb_rd == src) ? mwb_result : reg_data;
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX register with forwarding and ALU-control decode; ID_EX_PERF_CNT_EN adds bubble/stall counters
module id_ex_stage
    import core_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            flush,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [RA_W-1:0] id_rs1,
    input  logic [RA_W-1:0] id_rs2,
    input  logic [RA_W-1:0] id_rd,
    input  logic            id_alu_src,
    input  logic [1:0]      id_alu_op,
    input  logic [2:0]      id_funct3,
    input  logic            id_funct7b5,
    input  logic            id_mem_read,
    input  logic            id_mem_write,
    input  logic            id_reg_write,
    input  logic            id_mem_to_reg,
    input  logic            id_branch,
    input  logic            exm_reg_write,
    input  logic [RA_W-1:0] exm_rd,
    input  logic [XLEN-1:0] exm_result,
    input  logic            mwb_reg_write,
    input  logic [RA_W-1:0] mwb_rd,
    input  logic [XLEN-1:0] mwb_result,
    output logic [XLEN-1:0] ex_a,
    output logic [XLEN-1:0] ex_b,
    output logic [3:0]      ex_alu_ctl,
    output logic [XLEN-1:0] ex_store_data,
    output logic [RA_W-1:0] ex_rd,
`ifdef ID_EX_PERF_CNT_EN
    output logic [31:0]     bubble_cnt,
    output logic [31:0]     stall_cnt,
`endif
    output logic            ex_valid,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_reg_write,
    output logic            ex_mem_to_reg,
    output logic            ex_branch
);
    logic [XLEN-1:0] rs1_data, rs2_data, imm, fwd1, fwd2;
    logic [RA_W-1:0] rs1, rs2;
    logic [1:0]      alu_op;
    logic [2:0]      funct3;
    logic            alu_src, funct7b5, valid, mem_read, mem_write, reg_write, mem_to_reg, branch;

    // Flush loads data like a normal cycle but forces valid and controls to 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            {rs1_data, rs2_data, imm, rs1, rs2, ex_rd} <= '0;
            {alu_src, alu_op, funct3, funct7b5} <= '0;
            {valid, mem_read, mem_write, reg_write, mem_to_reg, branch} <= '0;
        end else if (flush || !stall) begin
            {rs1_data, rs2_data, imm} <= {id_rs1_data, id_rs2_data, id_imm};
            {rs1, rs2, ex_rd} <= {id_rs1, id_rs2, id_rd};
            {alu_src, alu_op, funct3, funct7b5} <= {id_alu_src, id_alu_op, id_funct3, id_funct7b5};
            valid <= id_valid && !flush;
            mem_read <= id_mem_read && !flush;
            mem_write <= id_mem_write && !flush;
            reg_write <= id_reg_write && !flush;
            mem_to_reg <= id_mem_to_reg && !flush;
            branch <= id_branch && !flush;
        end
    end

`ifdef ID_EX_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (flush && bubble_cnt != '1) bubble_cnt <= bubble_cnt + 32'd1;
            if (stall && !flush && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

    fwd_mux u_fwd1 (
        .src(rs1), .reg_data(rs1_data),
        .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
        .mwb_reg_write(mwb_reg_write), .mwb_rd(mwb_rd), .mwb_result(mwb_result),
        .data(fwd1)
    );

    fwd_mux u_fwd2 (
        .src(rs2), .reg_data(rs2_data),
        .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
        .mwb_reg_write(mwb_reg_write), .mwb_rd(mwb_rd), .mwb_result(mwb_result),
        .data(fwd2)
    );

    assign ex_a = fwd1;
    assign ex_store_data = fwd2;
    assign ex_b = alu_src ? imm : fwd2;
    assign ex_alu_ctl = alu_decode(alu_op, funct3, funct7b5, alu_src);
    assign ex_valid = valid;
    assign ex_mem_read = mem_read && valid;
    assign ex_mem_write = mem_write && valid;
    assign ex_reg_write = reg_write && valid;
    assign ex_mem_to_reg = mem_to_reg && valid;
    assign ex_branch = branch && valid;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed vectors for id_ex_stage; perf counters checked when ID_EX_PERF_CNT_EN is defined
module tb_id_ex_stage;
    logic        clk = 0, reset, stall, flush, id_valid;
    logic [63:0] id_rs1_data, id_rs2_data, id_imm, exm_result, mwb_result;
    logic [4:0]  id_rs1, id_rs2, id_rd, exm_rd, mwb_rd;
    logic        id_alu_src, id_funct7b5;
    logic [1:0]  id_alu_op;
    logic [2:0]  id_funct3;
    logic        id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg, id_branch;
    logic        exm_reg_write, mwb_reg_write;
    logic [63:0] ex_a, ex_b, ex_store_data;
    logic [3:0]  ex_alu_ctl;
    logic [4:0]  ex_rd;
    logic        ex_valid, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_branch;
`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] bubble_cnt, stall_cnt;
`endif
    int vecs = 0, errs = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_alu_src(id_alu_src),
        .id_alu_op(id_alu_op), .id_funct3(id_funct3), .id_funct7b5(id_funct7b5),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_reg_write(id_reg_write),
        .id_mem_to_reg(id_mem_to_reg), .id_branch(id_branch),
        .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
        .mwb_reg_write(mwb_reg_write), .mwb_rd(mwb_rd), .mwb_result(mwb_result),
        .ex_a(ex_a), .ex_b(ex_b), .ex_alu_ctl(ex_alu_ctl), .ex_store_data(ex_store_data),
        .ex_rd(ex_rd),
`ifdef ID_EX_PERF_CNT_EN
        .bubble_cnt(bubble_cnt), .stall_cnt(stall_cnt),
`endif
        .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        {stall, flush, id_valid, id_alu_src, id_funct7b5} = '0;
        {id_rs1_data, id_rs2_data, id_imm} = '0;
        {id_rs1, id_rs2, id_rd, id_alu_op, id_funct3} = '0;
        {id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg, id_branch} = '0;
        {exm_reg_write, exm_rd, exm_result, mwb_reg_write, mwb_rd, mwb_result} = '0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1;
        id_valid = 1; id_reg_write = 1; id_rs1_data = 64'h99; id_rd = 5'd3;
        step();
        reset = 0;
        idle();
        stall = 1;
        step();
        stall = 0;
        vecs++;
        if ({ex_valid, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_branch} !== 6'b0) begin
            errs++; $display("FAIL reset_ctl got %b want 000000",
                {ex_valid, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_branch});
        end
        vecs++;
        if (ex_alu_ctl !== 4'b0010) begin errs++; $display("FAIL reset_aluctl got %b want 0010", ex_alu_ctl); end
        vecs++;
        if ({ex_a, ex_b, ex_rd} !== '0) begin errs++; $display("FAIL reset_data a=%h b=%h rd=%0d want 0", ex_a, ex_b, ex_rd); end
    endtask

    task automatic test_alu_sub();
        idle();
        id_valid = 1; id_rs1_data = 64'd5; id_rs2_data = 64'd3; id_rs1 = 5'd1; id_rs2 = 5'd2;
        id_rd = 5'd4; id_reg_write = 1; id_alu_op = 2'b10; id_funct3 = 3'b000; id_funct7b5 = 1;
        step();
        vecs++;
        if ({ex_a, ex_b} !== {64'd5, 64'd3}) begin errs++; $display("FAIL sub_ops a=%h b=%h want 5 3", ex_a, ex_b); end
        vecs++;
        if (ex_alu_ctl !== 4'b0110) begin errs++; $display("FAIL sub_ctl got %b want 0110", ex_alu_ctl); end
        vecs++;
        if ({ex_valid, ex_reg_write, ex_rd} !== {2'b11, 5'd4}) begin
            errs++; $display("FAIL sub_ctrl valid=%b rw=%b rd=%0d want 1 1 4", ex_valid, ex_reg_write, ex_rd);
        end
    endtask

    task automatic test_addi();
        id_alu_src = 1; id_imm = '1; id_funct7b5 = 1;
        step();
        vecs++;
        if (ex_b !== 64'hFFFF_FFFF_FFFF_FFFF) begin errs++; $display("FAIL addi_b got %h want all ones", ex_b); end
        vecs++;
        if (ex_alu_ctl !== 4'b0010) begin errs++; $display("FAIL addi_ctl got %b want 0010", ex_alu_ctl); end
        vecs++;
        if (ex_store_data !== 64'd3) begin errs++; $display("FAIL addi_store got %h want 3", ex_store_data); end
    endtask

    task automatic test_alu_decode();
        logic [10:0] tbl [7];
        tbl[0] = {2'b10, 3'b111, 1'b0, 1'b0, 4'b0000};
        tbl[1] = {2'b10, 3'b110, 1'b1, 1'b0, 4'b0001};
        tbl[2] = {2'b01, 3'b000, 1'b0, 1'b1, 4'b0110};
        tbl[3] = {2'b11, 3'b000, 1'b1, 1'b0, 4'b0010};
        tbl[4] = {2'b10, 3'b100, 1'b1, 1'b0, 4'b0010};
        tbl[5] = {2'b00, 3'b000, 1'b1, 1'b0, 4'b0010};
        tbl[6] = {2'b10, 3'b000, 1'b0, 1'b0, 4'b0010};
        for (int i = 0; i < 7; i++) begin
            {id_alu_op, id_funct3, id_funct7b5, id_alu_src} = tbl[i][10:4];
            step();
            vecs++;
            if (ex_alu_ctl !== tbl[i][3:0]) begin
                errs++; $display("FAIL decode_%0d got %b want %b", i, ex_alu_ctl, tbl[i][3:0]);
            end
        end
    endtask

    task automatic test_forward();
        idle();
        id_valid = 1; id_rs1 = 5'd7; id_rs1_data = 64'h11; id_rs2 = 5'd7; id_rs2_data = 64'h33;
        step();
        exm_reg_write = 1; exm_rd = 5'd7; exm_result = 64'hAA;
        mwb_reg_write = 1; mwb_rd = 5'd7; mwb_result = 64'hBB;
        #1;
        vecs++;
        if (ex_a !== 64'hAA) begin errs++; $display("FAIL fwd_exm got %h want aa", ex_a); end
        vecs++;
        if ({ex_b, ex_store_data} !== {64'hAA, 64'hAA}) begin errs++; $display("FAIL fwd_exm_rs2 b=%h sd=%h want aa", ex_b, ex_store_data); end
        exm_reg_write = 0;
        #1;
        vecs++;
        if (ex_a !== 64'hBB) begin errs++; $display("FAIL fwd_mwb got %h want bb", ex_a); end
        mwb_reg_write = 0;
        #1;
        vecs++;
        if ({ex_a, ex_b} !== {64'h11, 64'h33}) begin errs++; $display("FAIL fwd_none a=%h b=%h want 11 33", ex_a, ex_b); end
        id_rs1 = 5'd0; id_rs1_data = 64'h22; id_rs2 = 5'd0; id_rs2_data = 64'h44;
        exm_reg_write = 1; exm_rd = 5'd0; mwb_reg_write = 1; mwb_rd = 5'd0;
        step();
        vecs++;
        if ({ex_a, ex_b} !== {64'h22, 64'h44}) begin errs++; $display("FAIL fwd_x0 a=%h b=%h want 22 44", ex_a, ex_b); end
    endtask

    task automatic test_stall();
        idle();
        id_valid = 1; id_rs1 = 5'd3; id_rs1_data = 64'h55; id_rd = 5'd9; id_reg_write = 1; id_mem_read = 1;
        step();
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            id_rs1_data = 64'h100 + 64'(i); id_rd = 5'(i + 20); id_valid = 0; id_reg_write = 0; id_alu_op = 2'b01;
            step();
            vecs++;
            if ({ex_a, ex_rd, ex_valid, ex_reg_write, ex_mem_read, ex_alu_ctl} !== {64'h55, 5'd9, 3'b111, 4'b0010}) begin
                errs++; $display("FAIL stall_hold_%0d a=%h rd=%0d v=%b rw=%b ctl=%b want 55 9 1 1 0010",
                    i, ex_a, ex_rd, ex_valid, ex_reg_write, ex_alu_ctl);
            end
        end
        exm_reg_write = 1; exm_rd = 5'd3; exm_result = 64'h77;
        #1;
        vecs++;
        if (ex_a !== 64'h77) begin errs++; $display("FAIL stall_fwd got %h want 77", ex_a); end
        exm_reg_write = 0;
        stall = 0; id_valid = 1; id_reg_write = 1; id_rd = 5'd12;
        step();
        vecs++;
        if ({ex_valid, ex_rd, ex_alu_ctl} !== {1'b1, 5'd12, 4'b0110}) begin
            errs++; $display("FAIL stall_release v=%b rd=%0d ctl=%b want 1 12 0110", ex_valid, ex_rd, ex_alu_ctl);
        end
        stall = 1; flush = 1;
        step();
        vecs++;
        if ({ex_valid, ex_reg_write, ex_mem_read} !== 3'b000) begin
            errs++; $display("FAIL stall_flush v=%b rw=%b mr=%b want 000", ex_valid, ex_reg_write, ex_mem_read);
        end
        stall = 0; flush = 0; id_branch = 1; id_mem_write = 1; id_mem_to_reg = 1;
        step();
        vecs++;
        if ({ex_valid, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_branch} !== 6'b111111) begin
            errs++; $display("FAIL all_ctrl got %b want 111111",
                {ex_valid, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_branch});
        end
        flush = 1;
        step();
        flush = 0;
        vecs++;
        if ({ex_valid, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_branch} !== 6'b0) begin
            errs++; $display("FAIL flush_ctrl got %b want 000000",
                {ex_valid, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_branch});
        end
    endtask

`ifdef ID_EX_PERF_CNT_EN
    task automatic test_perf();
        idle();
        reset = 1;
        step();
        reset = 0;
        flush = 1;
        step();
        step();
        flush = 0; stall = 1;
        step();
        step();
        step();
        stall = 0;
        step();
        vecs++;
        if ({bubble_cnt, stall_cnt} !== {32'd2, 32'd3}) begin
            errs++; $display("FAIL perf_cnt bubble=%0d stall=%0d want 2 3", bubble_cnt, stall_cnt);
        end
        reset = 1;
        step();
        reset = 0;
        vecs++;
        if ({bubble_cnt, stall_cnt} !== 64'd0) begin
            errs++; $display("FAIL perf_reset bubble=%0d stall=%0d want 0 0", bubble_cnt, stall_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_alu_sub();
        test_addi();
        test_alu_decode();
        test_forward();
        test_stall();
`ifdef ID_EX_PERF_CNT_EN
        test_perf();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register plus execute-operand preparation for the 64-bit pipelined RISC-V core.
- Captures decoded operands and control from ID each cycle, then drives the EX-stage ALU:
  - operands a and b, with EX/MEM and MEM/WB forwarding applied;
  - 4-bit ALUOp.
- Provides stall (hold) and flush (bubble insert) for the hazard unit. Sits directly upstream of the ALU.

Parameters:
- XLEN, 64, datapath width.
- RA_W, 5, register-address width.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- stall  in  1  hold all ID/EX registers this cycle
- flush  in  1  load bubble (valid=0, all control 0) this cycle
- id_valid  in  1  ID holds a real instruction
- id_rs1_data  in  XLEN  register-file read 1
- id_rs2_data  in  XLEN  register-file read 2
- id_imm  in  XLEN  sign-extended immediate
- id_rs1, id_rs2, id_rd  in  RA_W  register addresses
- id_alu_src  in  1  1 = operand b is immediate
- id_alu_op  in  2  00 add, 01 sub, 10 funct decode
- id_funct3  in  3  instruction funct3
- id_funct7b5  in  1  instruction bit 30
- id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg, id_branch  in  1 each  control
- exm_reg_write  in  1  EX/MEM writes a register
- exm_rd  in  RA_W  EX/MEM destination register
- exm_result  in  XLEN  EX/MEM ALU result
- mwb_reg_write  in  1  MEM/WB writes a register
- mwb_rd  in  RA_W  MEM/WB destination register
- mwb_result  in  XLEN  MEM/WB writeback data
- ex_a  out  XLEN  ALU input a
- ex_b  out  XLEN  ALU input b
- ex_alu_ctl  out  4  ALU operation select
- ex_store_data  out  XLEN  forwarded rs2, for stores
- ex_rd  out  RA_W  registered rd
- ex_valid, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_branch  out  1 each  registered controls, gated by valid

Behaviour:
- Single clock domain.
- Reset is synchronous and active-high: `reset` is sampled on the rising edge of `clk`.
- On reset, every registered field is 0. Resulting outputs:
  - ex_valid=0 and all control outputs 0;
  - ex_rd=0;
  - ex_alu_ctl=4'b0010 (add, from alu_op=00);
  - ex_a/ex_b=0 unless forwarding matches rd=0, which is never allowed.
- Per-edge priority:
  1. reset;
  2. flush (bubble: valid and all controls 0; data fields may load);
  3. stall (hold everything);
  4. normal load of all id_* inputs.
- stall and flush together: flush wins.
- Stall held N cycles: outputs constant for N cycles. Forwarded values still track the exm/mwb inputs combinationally.
- Latency: one cycle from ID inputs to registered state. Forwarding and ALU-control decode are combinational from registered state plus the exm/mwb inputs.
- Forwarding, for src in {rs1, rs2}:
  - If exm_reg_write && exm_rd!=0 && exm_rd==src, use exm_result.
  - Else if mwb_reg_write && mwb_rd!=0 && mwb_rd==src, use mwb_result.
  - Else use the registered read data.
  - EX/MEM has priority over MEM/WB.
  - x0 is never forwarded.
- Operand mapping:
  - ex_a = forwarded rs1.
  - ex_store_data = forwarded rs2.
  - ex_b = alu_src ? imm : forwarded rs2.
- ALU control:
  - alu_op 00 → 0010 (add).
  - alu_op 01 → 0110 (sub).
  - alu_op 10, by funct3:
    - 000 → 0110 if funct7b5 && !alu_src, else 0010;
    - 111 → 0000 (and);
    - 110 → 0001 (or);
    - any other → 0010.
  - alu_op 11 → 0010.
- Control outputs are gated by valid: each is its registered bit AND ex_valid.

Optional Feature:
- Macro: ID_EX_PERF_CNT_EN.
- Defined:
  - Adds outputs bubble_cnt (32) and stall_cnt (32).
  - bubble_cnt increments on each edge where flush=1 and reset=0.
  - stall_cnt increments on each edge where stall=1, flush=0 and reset=0.
  - Both saturate at 32'hFFFF_FFFF and clear on reset.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package core_pkg:
  - XLEN and RA_W;
  - ALU control localparams ALU_AND=4'b0000, ALU_OR=4'b0001, ALU_ADD=4'b0010, ALU_SUB=4'b0110;
  - alu_op encodings AOP_ADD=2'b00, AOP_SUB=2'b01, AOP_FUNCT=2'b10.
- One natural sub-module: fwd_mux. It is purely combinational, takes one source address, registered data and both forwarding sources, and is instantiated twice.

Test Plan:
- Reset, then release with idle inputs → ex_valid=0, all controls 0, ex_alu_ctl=4'b0010.
- Load rs1_data=5, rs2_data=3, alu_op=10, funct3=000, funct7b5=1, alu_src=0 → next cycle ex_a=5, ex_b=3, ex_alu_ctl=0110.
- Same instruction with alu_src=1, imm=-1, funct7b5=1 → ex_b=64'hFFFF_FFFF_FFFF_FFFF, ex_alu_ctl=0010 (addi, never sub).
- Registered rs1=7; exm_rd=7 with exm_result=0xAA; mwb_rd=7 with mwb_result=0xBB; both reg_write=1 → ex_a=0xAA. Drop exm_reg_write → ex_a=0xBB. Set exm_rd=mwb_rd=0 with registered rs1=0 → no forwarding.
- stall=1 for 3 cycles while id_* inputs change → outputs unchanged. Assert stall=1 and flush=1 in the same cycle → next cycle ex_valid=0 and ex_reg_write=0.
- With ID_EX_PERF_CNT_EN defined: 2 flushes, 3 stalls, then reset → bubble_cnt=2, stall_cnt=3, then both 0 after reset.
